// File: rtl/bitinfo_read_arbiter_if.sv
// Requester-side channel of the bitinfo ROM read arbiter: one burst request
// (start byte address + word count) and a valid/ready stream of data beats.
interface bitinfo_read_arbiter_if #(
    parameter int LEN_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [LEN_W-1:0] req_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_last;

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/bitinfo_read_arbiter.sv
// Round-robin arbiter sharing the single read port of the bitinfo ROM between
// the host bridge and the manager config fetch; streams bursts without a FIFO.
module bitinfo_read_arbiter #(
    parameter int DEPTH = 512,
    parameter int LEN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    bitinfo_read_arbiter_if.slave  host,
    bitinfo_read_arbiter_if.slave  mgr,
    output logic                   mem_en,
    output logic [31:0]            mem_addr,
    input  logic [31:0]            mem_dout
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state;
    logic             gnt;
    logic             last_gnt;
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] remaining;
    logic             pending;
    logic             last_pend;

    logic             in_idle;
    logic             in_burst;
    logic             host_win;
    logic             mgr_win;
    logic [IDX_W-1:0] start_idx;
    logic [LEN_W-1:0] start_len;
    logic             rsp_ready_g;
    logic             accept_beat;
    logic             issue;
    logic             burst_done;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        in_idle     = (state == S_IDLE);
        in_burst    = (state == S_BURST);
        host_win    = host.req_valid & (!mgr.req_valid | last_gnt);
        mgr_win     = mgr.req_valid & !host_win;
        start_idx   = mgr_win ? mgr.req_addr[IDX_W+1:2] : host.req_addr[IDX_W+1:2];
        start_len   = mgr_win ? mgr.req_len : host.req_len;
        rsp_ready_g = gnt ? mgr.rsp_ready : host.rsp_ready;
        accept_beat = in_burst & pending & rsp_ready_g;
        // A new read may replace the held word only once that word has been taken.
        issue       = in_burst & (remaining != '0) & (!pending | accept_beat);
        burst_done  = in_burst & ((accept_beat & last_pend) | (!pending & (remaining == '0)));
    end

    assign host.req_ready = in_idle & host_win;
    assign mgr.req_ready  = in_idle & mgr_win;

    assign host.rsp_valid = pending & !gnt;
    assign mgr.rsp_valid  = pending & gnt;
    assign host.rsp_last  = pending & !gnt & last_pend;
    assign mgr.rsp_last   = pending & gnt & last_pend;
    assign host.rsp_data  = mem_dout;
    assign mgr.rsp_data   = mem_dout;

    assign mem_en   = issue;
    assign mem_addr = {{(30-IDX_W){1'b0}}, idx, 2'b00};

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, host.req_addr[31:IDX_W+2], host.req_addr[1:0],
                                mgr.req_addr[31:IDX_W+2], mgr.req_addr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            idx       <= '0;
            remaining <= '0;
            pending   <= 1'b0;
            last_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host_win | mgr_win) begin
                        gnt       <= mgr_win;
                        last_gnt  <= mgr_win;
                        idx       <= start_idx;
                        remaining <= start_len;
                        pending   <= 1'b0;
                        state     <= S_BURST;
                    end
                end
                default: begin
                    if (issue) begin
                        idx       <= idx + IDX_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        pending   <= 1'b1;
                        last_pend <= (remaining == LEN_W'(1));
                    end else if (accept_beat) begin
                        pending <= 1'b0;
                    end
                    if (burst_done) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    mem_addr_legal: assert property (@(posedge clk) disable iff (rst)
        mem_en |-> (mem_addr[1:0] == 2'b00) && (mem_addr[31:IDX_W+2] == '0));

    single_rsp_valid: assert property (@(posedge clk) disable iff (rst)
        !(host.rsp_valid && mgr.rsp_valid));
endmodule
